// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared definitions for fifo_issue_arbiter. Holds the arbiter
//               FSM state encoding and the output-width helper.
// Config      : FIFO_ISSUE_ARBITER_TAG_EN - when defined, the arbiter prefixes
//               each payload sent to the queue with the winning requester id.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } arb_state_e;

`ifdef FIFO_ISSUE_ARBITER_TAG_EN
    localparam bit C_TAG_EN = 1'b1;
`else
    localparam bit C_TAG_EN = 1'b0;
`endif

    // Width of the word presented to the queue: payload, plus the winner id
    // in the MSBs when tagging is enabled.
    function automatic int calc_out_w(input int entry_w, input int id_w);
        return entry_w + (C_TAG_EN ? id_w : 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/round_robin_picker.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_picker
// Description : Combinational round-robin selector. Searches the valid vector
//               starting one position after last_grant_i, wrapping to 0, and
//               returns the first set index.
// Ports       : valid_i      - per-requester valid vector
//               last_grant_i - index served most recently
//               any_valid_o  - at least one valid bit set
//               winner_o     - selected index (0 when nothing is valid)
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_picker #(
    parameter int NUM_REQUESTERS     = 4,
    parameter int REQUESTER_ID_WIDTH = 2
) (
    input  logic [NUM_REQUESTERS-1:0]     valid_i,
    input  logic [REQUESTER_ID_WIDTH-1:0] last_grant_i,
    output logic                          any_valid_o,
    output logic [REQUESTER_ID_WIDTH-1:0] winner_o
);

    logic [2*NUM_REQUESTERS-1:0] w_double;
    logic [2*NUM_REQUESTERS-1:0] w_masked;
    logic                        w_found;
    int                          w_start;

    // The valid vector is duplicated so a plain LSB-first priority scan over
    // the masked lower copy plus the full upper copy yields the wrapped
    // round-robin order without any modulo arithmetic.
    always_comb begin
        // Explicit wrap: the last index rolls to 0, out-of-range also restarts at 0.
        if (int'(last_grant_i) >= NUM_REQUESTERS - 1) begin
            w_start = 0;
        end else begin
            w_start = int'(last_grant_i) + 1;
        end

        w_double = {valid_i, valid_i};
        for (int i = 0; i < 2 * NUM_REQUESTERS; i++) begin
            w_masked[i] = w_double[i] && (i >= w_start);
        end

        any_valid_o = |valid_i;
        winner_o    = '0;
        w_found     = 1'b0;
        for (int i = 0; i < 2 * NUM_REQUESTERS; i++) begin
            if (w_masked[i] && !w_found) begin
                w_found = 1'b1;
                if (i >= NUM_REQUESTERS) begin
                    winner_o = REQUESTER_ID_WIDTH'(i - NUM_REQUESTERS);
                end else begin
                    winner_o = REQUESTER_ID_WIDTH'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_issue_arbiter
// Description : Round-robin arbiter sharing one fifo_queue write port among
//               NUM_REQUESTERS requesters over a valid / issue-ack handshake.
//               Sequence per transfer: IDLE (pick + latch) -> GRANT (valid
//               held until queue ack) -> ACK (requester ack pulse, update
//               round-robin pointer) -> IDLE.
// Config      : FIFO_ISSUE_ARBITER_TAG_EN - when defined, request_out carries
//               {winner id, payload}; otherwise payload only.
// Ports       : clk_in            - clock
//               reset_in          - asynchronous active-high reset
//               request_in        - packed payloads, requester i at [i*W +: W]
//               request_valid_in  - per-requester valid, held until its ack
//               issue_ack_out     - per-requester one-cycle ack pulse
//               request_out       - word to the queue (registered)
//               request_valid_out - valid to the queue (registered)
//               issue_ack_in      - queue ack pulse
//               grant_id_out      - index of current / last winner
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_issue_arbiter import fifo_arb_pkg::*; #(
    parameter int  NUM_REQUESTERS             = 4,
    parameter int  REQUESTER_ID_WIDTH         = 2,
    parameter int  SINGLE_ENTRY_WIDTH_IN_BITS = 32,
    localparam int OUT_W = calc_out_w(SINGLE_ENTRY_WIDTH_IN_BITS, REQUESTER_ID_WIDTH)
) (
    input  logic                                             clk_in,
    input  logic                                             reset_in,
    input  logic [NUM_REQUESTERS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
    input  logic [NUM_REQUESTERS-1:0]                        request_valid_in,
    output logic [NUM_REQUESTERS-1:0]                        issue_ack_out,
    output logic [OUT_W-1:0]                                 request_out,
    output logic                                             request_valid_out,
    input  logic                                             issue_ack_in,
    output logic [REQUESTER_ID_WIDTH-1:0]                    grant_id_out
);

    localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;

    arb_state_e                      state_q,         state_d;
    logic [REQUESTER_ID_WIDTH-1:0]   winner_q,        winner_d;
    logic [REQUESTER_ID_WIDTH-1:0]   last_grant_q,    last_grant_d;
    logic [NUM_REQUESTERS-1:0]       issue_ack_q,     issue_ack_d;
    logic [OUT_W-1:0]                request_out_q,   request_out_d;
    logic                            request_valid_q, request_valid_d;

    logic                            w_any_valid;
    logic [REQUESTER_ID_WIDTH-1:0]   w_pick;
    logic [W-1:0]                    w_sel_payload;

    round_robin_picker #(
        .NUM_REQUESTERS     (NUM_REQUESTERS),
        .REQUESTER_ID_WIDTH (REQUESTER_ID_WIDTH)
    ) u_picker (
        .valid_i      (request_valid_in),
        .last_grant_i (last_grant_q),
        .any_valid_o  (w_any_valid),
        .winner_o     (w_pick)
    );

    // Payload mux for the requester the picker selected this cycle.
    always_comb begin
        w_sel_payload = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (int'(w_pick) == i) begin
                w_sel_payload = request_in[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q         <= IDLE;
            winner_q        <= '0;
            last_grant_q    <= REQUESTER_ID_WIDTH'(NUM_REQUESTERS - 1);
            issue_ack_q     <= '0;
            request_out_q   <= '0;
            request_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            winner_q        <= winner_d;
            last_grant_q    <= last_grant_d;
            issue_ack_q     <= issue_ack_d;
            request_out_q   <= request_out_d;
            request_valid_q <= request_valid_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        winner_d        = winner_q;
        last_grant_d    = last_grant_q;
        issue_ack_d     = '0;              // ack is a single-cycle pulse
        request_out_d   = request_out_q;   // holds the latched payload in GRANT
        request_valid_d = request_valid_q;

        case (state_q)
            IDLE: begin
                if (w_any_valid) begin
                    winner_d        = w_pick;
`ifdef FIFO_ISSUE_ARBITER_TAG_EN
                    request_out_d   = {w_pick, w_sel_payload};
`else
                    request_out_d   = w_sel_payload;
`endif
                    request_valid_d = 1'b1;
                    state_d         = GRANT;
                end
            end
            GRANT: begin
                // No timeout: a full queue simply keeps us here with valid held.
                if (issue_ack_in) begin
                    request_valid_d = 1'b0;
                    request_out_d   = '0;
                    for (int i = 0; i < NUM_REQUESTERS; i++) begin
                        issue_ack_d[i] = (int'(winner_q) == i);
                    end
                    state_d = ACK;
                end
            end
            ACK: begin
                // Extra cycle lets the winner drop its valid before IDLE
                // samples the request vector again.
                last_grant_d = winner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign issue_ack_out     = issue_ack_q;
    assign request_out       = request_out_q;
    assign request_valid_out = request_valid_q;
    assign grant_id_out      = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_issue_arbiter
// Description : Directed self-checking bench for fifo_issue_arbiter with a
//               small queue model that acks one cycle after it writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_issue_arbiter;
    import fifo_arb_pkg::*;

    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int W     = 32;
    localparam int OUT_W = calc_out_w(W, IDW);

    logic               clk_in;
    logic               reset_in;
    logic [N*W-1:0]     request_in;
    logic [N-1:0]       request_valid_in;
    logic [N-1:0]       issue_ack_out;
    logic [OUT_W-1:0]   request_out;
    logic               request_valid_out;
    logic               issue_ack_in;
    logic [IDW-1:0]     grant_id_out;

    logic               q_en;
    int                 checks;
    int                 failures;

    fifo_issue_arbiter #(
        .NUM_REQUESTERS             (N),
        .REQUESTER_ID_WIDTH         (IDW),
        .SINGLE_ENTRY_WIDTH_IN_BITS (W)
    ) dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .request_in        (request_in),
        .request_valid_in  (request_valid_in),
        .issue_ack_out     (issue_ack_out),
        .request_out       (request_out),
        .request_valid_out (request_valid_out),
        .issue_ack_in      (issue_ack_in),
        .grant_id_out      (grant_id_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Queue model: when enabled and not already acking, a valid seen before an
    // edge is written at that edge and acked during the following cycle.
    initial begin : queue_model
        logic pending;
        issue_ack_in = 1'b0;
        forever begin
            @(negedge clk_in);
            #1 pending = q_en && !reset_in && request_valid_out && !issue_ack_in;
            @(posedge clk_in);
            #1 issue_ack_in = pending;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // Expected queue word: in the tagged build the id sits above the payload,
    // otherwise the cast keeps only the payload.
    function automatic logic [OUT_W-1:0] exp_out(input logic [IDW-1:0] id, input logic [W-1:0] p);
        return OUT_W'({id, p});
    endfunction

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        repeat (2) tick();
        reset_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        repeat (2) tick();
        checks++; if (issue_ack_out !== '0) begin failures++; $display("FAIL reset_ack: got %b expected 0", issue_ack_out); end
        checks++; if (request_out !== '0) begin failures++; $display("FAIL reset_out: got %h expected 0", request_out); end
        checks++; if (request_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", request_valid_out); end
        checks++; if (grant_id_out !== '0) begin failures++; $display("FAIL reset_grant: got %0d expected 0", grant_id_out); end
        reset_in = 1'b0;
        tick();
        checks++; if (request_valid_out !== 1'b0) begin failures++; $display("FAIL idle_valid: got %b expected 0", request_valid_out); end
    endtask

    task automatic test_single();
        q_en = 1'b1;
        request_in[2*W +: W] = 32'hDEADBEEF;
        request_valid_in     = 4'b0100;
        tick();
        checks++; if (request_valid_out !== 1'b1) begin failures++; $display("FAIL single_valid0: got %b expected 1", request_valid_out); end
        checks++; if (request_out !== exp_out(2'd2, 32'hDEADBEEF)) begin failures++; $display("FAIL single_out: got %h expected %h", request_out, exp_out(2'd2, 32'hDEADBEEF)); end
        checks++; if (grant_id_out !== 2'd2) begin failures++; $display("FAIL single_grant: got %0d expected 2", grant_id_out); end
        checks++; if (issue_ack_out !== 4'b0000) begin failures++; $display("FAIL single_ack0: got %b expected 0000", issue_ack_out); end
        tick();
        checks++; if (request_valid_out !== 1'b1) begin failures++; $display("FAIL single_valid1: got %b expected 1", request_valid_out); end
        checks++; if (issue_ack_out !== 4'b0000) begin failures++; $display("FAIL single_ack1: got %b expected 0000", issue_ack_out); end
        tick();
        checks++; if (issue_ack_out !== 4'b0100) begin failures++; $display("FAIL single_ack2: got %b expected 0100", issue_ack_out); end
        checks++; if (request_valid_out !== 1'b0) begin failures++; $display("FAIL single_valid2: got %b expected 0", request_valid_out); end
        checks++; if (request_out !== '0) begin failures++; $display("FAIL single_out_clr: got %h expected 0", request_out); end
        request_valid_in = '0;
        tick();
        checks++; if (issue_ack_out !== 4'b0000) begin failures++; $display("FAIL single_ack3: got %b expected 0000", issue_ack_out); end
        checks++; if (grant_id_out !== 2'd2) begin failures++; $display("FAIL single_grant_hold: got %0d expected 2", grant_id_out); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0]   exp_ack;
        logic [IDW-1:0] exp_id;
        do_reset();
        q_en = 1'b1;
        for (int i = 0; i < N; i++) request_in[i*W +: W] = 32'hA000_0000 + i;
        request_valid_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_id  = IDW'(k % N);
            exp_ack = '0;
            exp_ack[exp_id] = 1'b1;
            tick();
            checks++; if (request_valid_out !== 1'b1) begin failures++; $display("FAIL rr_valid k=%0d: got %b expected 1", k, request_valid_out); end
            checks++; if (grant_id_out !== exp_id) begin failures++; $display("FAIL rr_grant k=%0d: got %0d expected %0d", k, grant_id_out, exp_id); end
            checks++; if (request_out !== exp_out(exp_id, 32'hA000_0000 + 32'(exp_id))) begin failures++; $display("FAIL rr_out k=%0d: got %h expected %h", k, request_out, exp_out(exp_id, 32'hA000_0000 + 32'(exp_id))); end
            tick();
            checks++; if (issue_ack_out !== 4'b0000) begin failures++; $display("FAIL rr_ack_early k=%0d: got %b expected 0000", k, issue_ack_out); end
            tick();
            checks++; if (issue_ack_out !== exp_ack) begin failures++; $display("FAIL rr_ack k=%0d: got %b expected %b", k, issue_ack_out, exp_ack); end
            tick();
            checks++; if (request_valid_out !== 1'b0) begin failures++; $display("FAIL rr_gap k=%0d: got %b expected 0", k, request_valid_out); end
        end
        request_valid_in = '0;
        tick();
    endtask

    task automatic test_pair();
        do_reset();
        q_en = 1'b1;
        request_in[1*W +: W] = 32'h1111_1111;
        request_in[3*W +: W] = 32'h3333_3333;
        request_valid_in = 4'b0010;
        tick();
        checks++; if (grant_id_out !== 2'd1) begin failures++; $display("FAIL pair_setup: got %0d expected 1", grant_id_out); end
        tick(); tick();
        request_valid_in = 4'b0000;
        tick();
        request_valid_in = 4'b1010;
        tick();
        checks++; if (grant_id_out !== 2'd3) begin failures++; $display("FAIL pair_first: got %0d expected 3", grant_id_out); end
        checks++; if (request_out !== exp_out(2'd3, 32'h3333_3333)) begin failures++; $display("FAIL pair_first_out: got %h expected %h", request_out, exp_out(2'd3, 32'h3333_3333)); end
        tick(); tick();
        checks++; if (issue_ack_out !== 4'b1000) begin failures++; $display("FAIL pair_ack3: got %b expected 1000", issue_ack_out); end
        request_valid_in = 4'b0010;
        tick(); tick();
        checks++; if (grant_id_out !== 2'd1) begin failures++; $display("FAIL pair_second: got %0d expected 1", grant_id_out); end
        checks++; if (request_out !== exp_out(2'd1, 32'h1111_1111)) begin failures++; $display("FAIL pair_second_out: got %h expected %h", request_out, exp_out(2'd1, 32'h1111_1111)); end
        tick(); tick();
        checks++; if (issue_ack_out !== 4'b0010) begin failures++; $display("FAIL pair_ack1: got %b expected 0010", issue_ack_out); end
        request_valid_in = '0;
        tick();
    endtask

    task automatic test_queue_full();
        do_reset();
        q_en = 1'b0;
        request_in[0 +: W] = 32'hCAFEF00D;
        request_valid_in   = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (request_valid_out !== 1'b1) begin failures++; $display("FAIL full_valid c=%0d: got %b expected 1", k, request_valid_out); end
            checks++; if (request_out !== exp_out(2'd0, 32'hCAFEF00D)) begin failures++; $display("FAIL full_out c=%0d: got %h expected %h", k, request_out, exp_out(2'd0, 32'hCAFEF00D)); end
            checks++; if (issue_ack_out !== 4'b0000) begin failures++; $display("FAIL full_ack c=%0d: got %b expected 0000", k, issue_ack_out); end
            request_in[0 +: W] = $urandom;   // latched payload must not follow
        end
        q_en = 1'b1;
        tick();
        checks++; if (issue_ack_out !== 4'b0000) begin failures++; $display("FAIL full_rel_ack0: got %b expected 0000", issue_ack_out); end
        checks++; if (request_valid_out !== 1'b1) begin failures++; $display("FAIL full_rel_valid: got %b expected 1", request_valid_out); end
        tick();
        checks++; if (issue_ack_out !== 4'b0001) begin failures++; $display("FAIL full_rel_ack: got %b expected 0001", issue_ack_out); end
        request_valid_in = '0;
        tick();
        checks++; if (issue_ack_out !== 4'b0000) begin failures++; $display("FAIL full_rel_ack_end: got %b expected 0000", issue_ack_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        q_en = 1'b0;
        request_in[0*W +: W] = 32'h0000_AAAA;
        request_in[1*W +: W] = 32'h1111_BBBB;
        request_valid_in = 4'b0010;
        tick();
        checks++; if (grant_id_out !== 2'd1) begin failures++; $display("FAIL mid_pre_grant: got %0d expected 1", grant_id_out); end
        #2 reset_in = 1'b1;
        #1;
        checks++; if (request_valid_out !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b expected 0", request_valid_out); end
        checks++; if (request_out !== '0) begin failures++; $display("FAIL mid_out: got %h expected 0", request_out); end
        checks++; if (grant_id_out !== '0) begin failures++; $display("FAIL mid_grant: got %0d expected 0", grant_id_out); end
        checks++; if (issue_ack_out !== '0) begin failures++; $display("FAIL mid_ack: got %b expected 0", issue_ack_out); end
        request_valid_in = 4'b0011;
        tick();
        reset_in = 1'b0;
        q_en     = 1'b1;
        tick();
        checks++; if (grant_id_out !== 2'd0) begin failures++; $display("FAIL mid_after_grant: got %0d expected 0", grant_id_out); end
        checks++; if (request_out !== exp_out(2'd0, 32'h0000_AAAA)) begin failures++; $display("FAIL mid_after_out: got %h expected %h", request_out, exp_out(2'd0, 32'h0000_AAAA)); end
        tick(); tick();
        checks++; if (issue_ack_out !== 4'b0001) begin failures++; $display("FAIL mid_after_ack: got %b expected 0001", issue_ack_out); end
        request_valid_in = '0;
        tick();
    endtask

`ifdef FIFO_ISSUE_ARBITER_TAG_EN
    task automatic test_tag();
        logic [OUT_W-1:0] exp_word;
        exp_word = 34'h3_12345678;
        do_reset();
        q_en = 1'b1;
        request_in[3*W +: W] = 32'h12345678;
        request_valid_in     = 4'b1000;
        tick();
        checks++; if (request_out !== exp_word) begin failures++; $display("FAIL tag_out: got %h expected %h", request_out, exp_word); end
        tick(); tick();
        checks++; if (issue_ack_out !== 4'b1000) begin failures++; $display("FAIL tag_ack: got %b expected 1000", issue_ack_out); end
        request_valid_in = '0;
        tick();
    endtask
`endif

    initial begin
        checks           = 0;
        failures         = 0;
        q_en             = 1'b1;
        reset_in         = 1'b1;
        request_in       = '0;
        request_valid_in = '0;

        test_reset();
        test_single();
        test_round_robin();
        test_pair();
        test_queue_full();
        test_reset_mid();
`ifdef FIFO_ISSUE_ARBITER_TAG_EN
        test_tag();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_issue_arbiter.md
# fifo_issue_arbiter

Round-robin arbiter that shares the single write port of a `fifo_queue` instance among `NUM_REQUESTERS` independent requesters. It sits between the requesters and the queue, and presents one request at a time using the queue's valid/issue-ack handshake. Each acknowledgement is a one-cycle pulse, returned to the requester that won arbitration. Grant order is fair: the last-served requester has lowest priority on the next pick.

## Interface
Parameters:
- `NUM_REQUESTERS`, 4, number of requester ports; minimum 2.
- `REQUESTER_ID_WIDTH`, 2, width of the requester index; must satisfy 2^`REQUESTER_ID_WIDTH` ≥ `NUM_REQUESTERS`.
- `SINGLE_ENTRY_WIDTH_IN_BITS`, 32, payload width per requester.

Ports:
- `clk_in`  in  1  clock.
- `reset_in`  in  1  reset; asynchronous, active-high.
- `request_in`  in  `NUM_REQUESTERS*SINGLE_ENTRY_WIDTH_IN_BITS`  packed payloads; requester i occupies slice [i*W +: W].
- `request_valid_in`  in  `NUM_REQUESTERS`  per-requester valid; held high until that requester's ack.
- `issue_ack_out`  out  `NUM_REQUESTERS`  per-requester one-cycle ack pulse; registered.
- `request_out`  out  `OUT_W`  payload to the queue; registered. `OUT_W` is defined under Configuration.
- `request_valid_out`  out  1  valid to the queue; registered.
- `issue_ack_in`  in  1  the queue's ack pulse, which arrives one cycle after the queue writes.
- `grant_id_out`  out  `REQUESTER_ID_WIDTH`  index of the current or last winner; registered.

## Operation
- FSM states:
  - IDLE
    - If any `request_valid_in` bit is high: latch the winner index and its payload, then go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT
    - `request_valid_out`=1 and `request_out` holds the latched payload.
    - When `issue_ack_in`=1: go to ACK, clear `request_valid_out` and `request_out`, and set `issue_ack_out[winner]`=1.
  - ACK
    - Clear `issue_ack_out`.
    - Set `last_grant`=winner.
    - Go to IDLE.
- Winner selection (round-robin):
  - Search starts at `last_grant`+1 and wraps modulo `NUM_REQUESTERS`.
  - The first requester with valid set wins.
  - `last_grant` resets to `NUM_REQUESTERS`-1, so requester 0 is first after reset.
- Wrap rule: an index equal to `NUM_REQUESTERS`-1 wraps to 0. Never rely on power-of-two overflow.
- Payload stability: the payload is latched on entry to GRANT. Later changes on `request_in` while in GRANT are ignored.
- Requester valid drop: the ACK cycle lets the winner drop or renew its valid before IDLE samples it again, so no double-issue can occur.
- `issue_ack_in` in IDLE or ACK: ignored.
- Queue full: the arbiter stays in GRANT indefinitely with valid held. There is no timeout.
- Deasserted valid: requesters whose valid is low are never granted.
- A requester that deasserts valid while it holds the grant is a protocol violation. The arbiter still completes the transfer.

## Timing
- Reset values: `issue_ack_out`=0, `request_out`=0, `request_valid_out`=0, `grant_id_out`=0, state=IDLE, `last_grant`=`NUM_REQUESTERS`-1.
- Latency:
  - Valid sampled in IDLE at edge t; `request_valid_out`=1 from t+1.
  - The queue writes at edge t+1 and returns `issue_ack_in` during cycle t+2.
  - `issue_ack_out` pulses during cycle t+3.
- Minimum initiation interval: 4 cycles per transfer (IDLE, GRANT×2, ACK).
- Reset mid-operation: all state clears immediately. An in-flight payload is dropped and no ack is issued.

## Configuration
- Macro: `FIFO_ISSUE_ARBITER_TAG_EN`.
- Defined:
  - `OUT_W` = `SINGLE_ENTRY_WIDTH_IN_BITS` + `REQUESTER_ID_WIDTH`.
  - `request_out` = {winner id, payload}, with the id in the MSBs. The downstream queue must be sized to `OUT_W`.
- Undefined:
  - `OUT_W` = `SINGLE_ENTRY_WIDTH_IN_BITS`.
  - `request_out` = payload only.

## Structure
- Package `fifo_arb_pkg` holds:
  - the FSM state encoding: IDLE=2'd0, GRANT=2'd1, ACK=2'd2;
  - a function that computes `OUT_W` from the widths and the macro.
- Sub-module `round_robin_picker` (purely combinational):
  - inputs: valid vector and `last_grant`;
  - outputs: `any_valid` and `winner` index;
  - implementation: a double-width masked priority search.
- Top level holds the FSM, the payload/winner registers, `last_grant` and the output registers.

## Test plan
- Single request, valid[2]=1, payload 0xDEADBEEF; model queue acks 1 cycle after valid:
  - `request_out`=0xDEADBEEF;
  - valid high 2 cycles;
  - `issue_ack_out`=4'b0100 for exactly 1 cycle;
  - `grant_id_out`=2.
- All four valid continuously after reset: grant order 0,1,2,3,0, one grant every 4 cycles.
- Requesters 1 and 3 valid, `last_grant`=1: requester 3 wins first, then requester 1.
- Model queue full for 10 cycles while in GRANT: `request_valid_out` stays 1 with stable payload; no ack until the queue acks.
- `reset_in` pulsed during GRANT: all outputs 0 within the same cycle; after release, requester 0 wins first if valid.
- With `FIFO_ISSUE_ARBITER_TAG_EN`, requester 3 sends 0x12345678: `request_out`=34'h3_12345678.
